// File: rtl/cia_tod.sv
// cia_tod: CIA time-of-day clock.
// Synchronizes the raw TOD pin, divides it to a 10 Hz tick, and keeps a 12-hour BCD
// clock with an AM/PM flag. Writing hr halts the clock and writing 10ths restarts it.
// Reading hr freezes a read latch until 10ths is read. An alarm compare raises irq_alrm.
// Optional macro CIA_TOD_HR12_FLIP_EN: an hr write of 12 stores pm inverted (6526 quirk).
module cia_tod (
  input  logic       clk,
  input  logic       rst,
  input  logic       tod_i,
  input  logic       todin,
  input  logic       alarm_sel,
  input  logic       we,
  input  logic       re,
  input  logic [1:0] addr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       irq_alrm
);

  // Synchronizer and edge-detect flops
  logic sync1_q, sync2_q, sync3_q;
  // Prescaler and run state
  logic [2:0] presc_q, presc_d;
  logic       running_q, running_d;
  // Live time, one BCD digit per field
  logic [3:0] tenths_q, tenths_d;
  logic [3:0] sec_lo_q, sec_lo_d;
  logic [2:0] sec_hi_q, sec_hi_d;
  logic [3:0] min_lo_q, min_lo_d;
  logic [2:0] min_hi_q, min_hi_d;
  logic [3:0] hr_lo_q, hr_lo_d;
  logic       hr_hi_q, hr_hi_d;
  logic       pm_q, pm_d;
  // Alarm (write-only)
  logic [3:0] al_tenths_q, al_tenths_d;
  logic [6:0] al_sec_q, al_sec_d;
  logic [6:0] al_min_q, al_min_d;
  logic [5:0] al_hr_q, al_hr_d;  // {pm, hr[4:0]}
  // Read latch
  logic       latched_q, latched_d;
  logic [7:0] lat_10_q, lat_10_d;
  logic [7:0] lat_sec_q, lat_sec_d;
  logic [7:0] lat_min_q, lat_min_d;
  logic [7:0] lat_hr_q, lat_hr_d;
  // Alarm edge detect
  logic match, match_q, irq_d;

  logic       tod_rise, presc_hit, tick, pm_wr;
  logic [4:0] inc_t, inc_sl, inc_sh, inc_ml, inc_mh;
  logic [3:0] hr_lo_inc;
  logic       hr_hi_inc, pm_inc;
  logic [7:0] live_10, live_sec, live_min, live_hr;

  // Add one to a BCD digit; returns {carry, next}. Carry and clear only at max, so
  // out-of-range digits count on to 15 and wrap silently.
  function automatic logic [4:0] inc_digit(input logic [3:0] d, input logic [3:0] max);
    if (d == max) begin
      return 5'b1_0000;
    end
    return {1'b0, d + 4'd1};
  endfunction

  assign live_10  = {4'd0, tenths_q};
  assign live_sec = {1'b0, sec_hi_q, sec_lo_q};
  assign live_min = {1'b0, min_hi_q, min_lo_q};
  assign live_hr  = {pm_q, 2'b00, hr_hi_q, hr_lo_q};

  assign tod_rise  = sync2_q & ~sync3_q;
  // Compare one below terminal so a count already past terminal wraps on the next edge
  assign presc_hit = todin ? (presc_q >= 3'd4) : (presc_q >= 3'd5);
  assign tick      = running_q & tod_rise & presc_hit;

  assign inc_t  = inc_digit(tenths_q, 4'd9);
  assign inc_sl = inc_digit(sec_lo_q, 4'd9);
  assign inc_sh = inc_digit({1'b0, sec_hi_q}, 4'd5);
  assign inc_ml = inc_digit(min_lo_q, 4'd9);
  assign inc_mh = inc_digit({1'b0, min_hi_q}, 4'd5);

  assign match = (tenths_q == al_tenths_q) && (live_sec[6:0] == al_sec_q) &&
                 (live_min[6:0] == al_min_q) && ({pm_q, hr_hi_q, hr_lo_q} == al_hr_q);

  // Hour step in 12-hour form: 11->12 flips pm, 12->01 keeps it
  always_comb begin
    hr_hi_inc = hr_hi_q;
    hr_lo_inc = hr_lo_q + 4'd1;
    pm_inc    = pm_q;
    if (hr_hi_q && hr_lo_q == 4'd1) begin
      hr_lo_inc = 4'd2;
      pm_inc    = ~pm_q;
    end else if (hr_hi_q && hr_lo_q == 4'd2) begin
      hr_hi_inc = 1'b0;
      hr_lo_inc = 4'd1;
    end else if (hr_lo_q == 4'd9) begin
      hr_hi_inc = ~hr_hi_q;
      hr_lo_inc = 4'd0;
    end
  end

  // pm value stored by a live hr write
  always_comb begin
`ifdef CIA_TOD_HR12_FLIP_EN
    pm_wr = (data_i[4:0] == 5'h12) ? ~data_i[7] : data_i[7];
`else
    pm_wr = data_i[7];
`endif
  end

  // Next state: prescaler, tick cascade, then writes override the written field
  always_comb begin
    presc_d     = presc_q;
    running_d   = running_q;
    tenths_d    = tenths_q;
    sec_lo_d    = sec_lo_q;
    sec_hi_d    = sec_hi_q;
    min_lo_d    = min_lo_q;
    min_hi_d    = min_hi_q;
    hr_lo_d     = hr_lo_q;
    hr_hi_d     = hr_hi_q;
    pm_d        = pm_q;
    al_tenths_d = al_tenths_q;
    al_sec_d    = al_sec_q;
    al_min_d    = al_min_q;
    al_hr_d     = al_hr_q;
    latched_d   = latched_q;
    lat_10_d    = lat_10_q;
    lat_sec_d   = lat_sec_q;
    lat_min_d   = lat_min_q;
    lat_hr_d    = lat_hr_q;
    irq_d       = match & ~match_q;

    if (running_q && tod_rise) begin
      presc_d = presc_hit ? 3'd0 : presc_q + 3'd1;
    end

    if (tick) begin
      tenths_d = inc_t[3:0];
      if (inc_t[4]) begin
        sec_lo_d = inc_sl[3:0];
        if (inc_sl[4]) begin
          sec_hi_d = inc_sh[2:0];
          if (inc_sh[4]) begin
            min_lo_d = inc_ml[3:0];
            if (inc_ml[4]) begin
              min_hi_d = inc_mh[2:0];
              if (inc_mh[4]) begin
                hr_hi_d = hr_hi_inc;
                hr_lo_d = hr_lo_inc;
                pm_d    = pm_inc;
              end
            end
          end
        end
      end
    end

    // Latch captures pre-update live values
    if (re) begin
      if (addr == 2'd3 && !latched_q) begin
        latched_d = 1'b1;
        lat_10_d  = live_10;
        lat_sec_d = live_sec;
        lat_min_d = live_min;
        lat_hr_d  = live_hr;
      end else if (addr == 2'd0) begin
        latched_d = 1'b0;
      end
    end

    if (we && !alarm_sel) begin
      unique case (addr)
        2'd0: begin
          tenths_d  = data_i[3:0];
          presc_d   = 3'd0;
          running_d = 1'b1;
        end
        2'd1: begin
          sec_hi_d = data_i[6:4];
          sec_lo_d = data_i[3:0];
        end
        2'd2: begin
          min_hi_d = data_i[6:4];
          min_lo_d = data_i[3:0];
        end
        2'd3: begin
          hr_hi_d   = data_i[4];
          hr_lo_d   = data_i[3:0];
          pm_d      = pm_wr;
          running_d = 1'b0;
        end
      endcase
    end else if (we && alarm_sel) begin
      unique case (addr)
        2'd0: al_tenths_d = data_i[3:0];
        2'd1: al_sec_d    = data_i[6:0];
        2'd2: al_min_d    = data_i[6:0];
        2'd3: al_hr_d     = {data_i[7], data_i[4:0]};
      endcase
    end
  end

  // Read mux: latch contents while latched, live otherwise
  always_comb begin
    data_o = 8'd0;
    unique case (addr)
      2'd0: data_o = latched_q ? lat_10_q  : live_10;
      2'd1: data_o = latched_q ? lat_sec_q : live_sec;
      2'd2: data_o = latched_q ? lat_min_q : live_min;
      2'd3: data_o = latched_q ? lat_hr_q  : live_hr;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      presc_q     <= 3'd0;
      running_q   <= 1'b0;
      tenths_q    <= 4'd0;
      sec_lo_q    <= 4'd0;
      sec_hi_q    <= 3'd0;
      min_lo_q    <= 4'd0;
      min_hi_q    <= 3'd0;
      hr_lo_q     <= 4'd1;
      hr_hi_q     <= 1'b0;
      pm_q        <= 1'b0;
      al_tenths_q <= 4'd0;
      al_sec_q    <= 7'd0;
      al_min_q    <= 7'd0;
      al_hr_q     <= 6'd0;
      latched_q   <= 1'b0;
      lat_10_q    <= 8'd0;
      lat_sec_q   <= 8'd0;
      lat_min_q   <= 8'd0;
      lat_hr_q    <= 8'd0;
      match_q     <= 1'b0;
      irq_alrm    <= 1'b0;
    end else begin
      sync1_q     <= tod_i;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      presc_q     <= presc_d;
      running_q   <= running_d;
      tenths_q    <= tenths_d;
      sec_lo_q    <= sec_lo_d;
      sec_hi_q    <= sec_hi_d;
      min_lo_q    <= min_lo_d;
      min_hi_q    <= min_hi_d;
      hr_lo_q     <= hr_lo_d;
      hr_hi_q     <= hr_hi_d;
      pm_q        <= pm_d;
      al_tenths_q <= al_tenths_d;
      al_sec_q    <= al_sec_d;
      al_min_q    <= al_min_d;
      al_hr_q     <= al_hr_d;
      latched_q   <= latched_d;
      lat_10_q    <= lat_10_d;
      lat_sec_q   <= lat_sec_d;
      lat_min_q   <= lat_min_d;
      lat_hr_q    <= lat_hr_d;
      match_q     <= match;
      irq_alrm    <= irq_d;
    end
  end

endmodule
